// File: rtl/riscv_pkg.sv
// riscv_pkg: constants, opcode encodings and datapath helpers shared by the
// RV32I core and the SoC memories.
//   ADDR_W / WORDS : byte-address width and word count of each 8 KiB memory
//   IDX_W          : word-index width (ADDR_W - 2)
//   MASK_*         : byte-lane write masks for sb / sh / sw
//   RESET_VECTOR   : first fetch address after reset
package riscv_pkg;

  localparam int ADDR_W = 13;
  localparam int WORDS  = 2048;
  localparam int IDX_W  = ADDR_W - 2;

  localparam logic [3:0]  MASK_B       = 4'b0001;
  localparam logic [3:0]  MASK_H       = 4'b0011;
  localparam logic [3:0]  MASK_W       = 4'b1111;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'h37,
    OPC_AUIPC  = 7'h17,
    OPC_JAL    = 7'h6f,
    OPC_JALR   = 7'h67,
    OPC_BRANCH = 7'h63,
    OPC_LOAD   = 7'h03,
    OPC_STORE  = 7'h23,
    OPC_OPIMM  = 7'h13,
    OPC_OP     = 7'h33
  } opcode_e;

  // Integer ALU; alt selects sub / sra.
  function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0: begin
        if (alt) r = a - b;
        else     r = a + b;
      end
      3'd1: r = a << b[4:0];
      3'd2: r = {31'd0, ($signed(a) < $signed(b))};
      3'd3: r = {31'd0, (a < b)};
      3'd4: r = a ^ b;
      3'd5: begin
        // Kept as two branches so the arithmetic shift stays signed.
        if (alt) r = $unsigned($signed(a) >>> b[4:0]);
        else     r = a >> b[4:0];
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Conditional-branch outcome from funct3.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] b);
    logic t;
    case (f3)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = ($signed(a) <  $signed(b));
      3'd5: t = ($signed(a) >= $signed(b));
      3'd6: t = (a <  b);
      3'd7: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Selects the byte/half addressed by off from a full word and extends it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [31:0] word,
                                              input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (f3)
      3'd0: r = {{24{sh[7]}}, sh[7:0]};
      3'd1: r = {{16{sh[15]}}, sh[15:0]};
      3'd4: r = {24'd0, sh[7:0]};
      3'd5: r = {16'd0, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram.sv
// ram: byte-banked data RAM built from four ram_byte lanes.
//   clk   : write clock
//   we    : store strobe from the core
//   wmask : per-lane enables; lane N holds bits 8N+7:8N
//   addr  : word index (mem_addr[12:2])
//   wdata : lane-aligned store data
//   rdata : {lane3, lane2, lane1, lane0} of the addressed word
module ram
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       wmask,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  ram_byte ram_byte0 (.clk(clk), .we(we & wmask[0]), .addr(addr),
                      .wdata(wdata[7:0]),   .rdata(rdata[7:0]));
  ram_byte ram_byte1 (.clk(clk), .we(we & wmask[1]), .addr(addr),
                      .wdata(wdata[15:8]),  .rdata(rdata[15:8]));
  ram_byte ram_byte2 (.clk(clk), .we(we & wmask[2]), .addr(addr),
                      .wdata(wdata[23:16]), .rdata(rdata[23:16]));
  ram_byte ram_byte3 (.clk(clk), .we(we & wmask[3]), .addr(addr),
                      .wdata(wdata[31:24]), .rdata(rdata[31:24]));

endmodule

// File: rtl/ram_byte.sv
// ram_byte: one 8-bit x WORDS byte lane of the data RAM.
//   clk   : write clock
//   we    : lane write enable (mem_we & wmask bit)
//   addr  : word index
//   wdata : byte to write
//   rdata : combinational read; a same-cycle write shows up next cycle
module ram_byte
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] memory [0:WORDS-1];

  // Lane write; contents persist across reset.
  always_ff @(posedge clk) begin
    if (we) begin
      memory[addr] <= wdata;
    end
  end

  assign rdata = memory[addr];

endmodule

// File: rtl/riscv.sv
// riscv: RV32I core, one instruction per clock using the zero-latency ROM
// and RAM reads. FENCE/SYSTEM and unknown opcodes execute as no-ops.
//   clk, rstn  : clock, async active-low reset (PC = 0, registers cleared)
//   inst_addr  : fetch address; inst : fetched word
//   mem_addr, mem_wdata, mem_we, mem_wmask, mem_re : data port
//   mem_rdata  : raw word read; byte/half selection is done here
module riscv
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  logic [31:0] pc_r;
  logic [31:0] EX_inst_addr;
  logic [31:0] MEM_jump_addr;
  logic        jump;
  logic [31:0] pc_plus4;
  logic        store_s;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  opcode_e     opcode;
  logic [2:0]  funct3;

  assign opcode = opcode_e'(inst[6:0]);
  assign funct3 = inst[14:12];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'h000};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign EX_inst_addr = pc_r;
  assign inst_addr    = pc_r;
  assign pc_plus4     = EX_inst_addr + 32'd4;

  // Effective address lives outside the decode block so the RAM read path
  // does not loop back through it.
  assign mem_addr = rs1_data + ((opcode == OPC_STORE) ? imm_s : imm_i);

  // A store presented while reset is asserted must never reach the RAM.
  assign mem_we = store_s & rstn;

  riscv_register register_inst (
    .clk      (clk),
    .rstn     (rstn),
    .rs1_addr (inst[19:15]),
    .rs2_addr (inst[24:20]),
    .rd_we    (wb_en),
    .rd_addr  (inst[11:7]),
    .rd_data  (wb_data),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  // Decode and execute: write-back, control flow and store steering.
  always_comb begin
    wb_en         = 1'b0;
    wb_data       = 32'h0;
    jump          = 1'b0;
    MEM_jump_addr = pc_plus4;
    store_s       = 1'b0;
    mem_re        = 1'b0;
    mem_wdata     = 32'h0;
    mem_wmask     = 4'h0;
    case (opcode)
      OPC_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OPC_AUIPC: begin
        wb_en   = 1'b1;
        wb_data = EX_inst_addr + imm_u;
      end
      OPC_JAL: begin
        wb_en         = 1'b1;
        wb_data       = pc_plus4;
        jump          = 1'b1;
        MEM_jump_addr = EX_inst_addr + imm_j;
      end
      OPC_JALR: begin
        wb_en         = 1'b1;
        wb_data       = pc_plus4;
        jump          = 1'b1;
        MEM_jump_addr = (rs1_data + imm_i) & 32'hFFFF_FFFE;
      end
      OPC_BRANCH: begin
        jump          = branch_taken(funct3, rs1_data, rs2_data);
        MEM_jump_addr = EX_inst_addr + imm_b;
      end
      OPC_LOAD: begin
        mem_re  = 1'b1;
        wb_en   = 1'b1;
        wb_data = load_extend(funct3, mem_rdata, mem_addr[1:0]);
      end
      OPC_STORE: begin
        store_s = 1'b1;
        // Replicate the datum across lanes; the mask picks the live lane(s).
        case (funct3)
          3'd0: begin
            mem_wdata = {4{rs2_data[7:0]}};
            mem_wmask = MASK_B << mem_addr[1:0];
          end
          3'd1: begin
            mem_wdata = {2{rs2_data[15:0]}};
            mem_wmask = MASK_H << {mem_addr[1], 1'b0};
          end
          default: begin
            mem_wdata = rs2_data;
            mem_wmask = MASK_W;
          end
        endcase
      end
      OPC_OPIMM: begin
        wb_en   = 1'b1;
        wb_data = alu_op(funct3, (funct3 == 3'd5) && inst[30], rs1_data, imm_i);
      end
      OPC_OP: begin
        wb_en   = 1'b1;
        wb_data = alu_op(funct3, inst[30], rs1_data, rs2_data);
      end
      default: begin
        wb_en = 1'b0;
      end
    endcase
  end

  // Program counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_r <= RESET_VECTOR;
    end else if (jump) begin
      pc_r <= MEM_jump_addr;
    end else begin
      pc_r <= pc_plus4;
    end
  end

endmodule

// File: rtl/riscv_register.sv
// riscv_register: 32 x 32-bit integer register file, two read / one write.
//   clk, rstn          : clock, async active-low reset (clears all registers)
//   rs1_addr/rs2_addr  : read addresses, combinational read data
//   rd_we/rd_addr/rd_data : write port; writes to x0 are dropped
module riscv_register (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic        rd_we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);

  logic [31:0] reg_mem [0:31];

  // Write port; x0 stays zero because it is never written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        reg_mem[i] <= 32'h0;
      end
    end else if (rd_we && (rd_addr != 5'd0)) begin
      reg_mem[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = reg_mem[rs1_addr];
  assign rs2_data = reg_mem[rs2_addr];

endmodule

// File: rtl/rom.sv
// rom: WORDS x 32-bit instruction memory with zero-latency read.
//   clk                          : clock for the (unused) image-load port
//   addr                         : word index (inst_addr[12:2])
//   data                         : instruction word at addr
//   load_en / load_idx / load_data : image-load port, tied off at the top so
//                                  the core can never write the ROM
module rom
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  output logic [31:0]      data,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [31:0]      load_data
);

  logic [31:0] memory [0:WORDS-1];

  // Image-load port; contents are never reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      memory[load_idx] <= load_data;
    end
  end

  assign data = memory[addr];

endmodule

// File: rtl/riscv_soc_top.sv
// riscv_soc_top: RV32I core + 8 KiB instruction ROM + 8 KiB byte-banked RAM.
//   clk           : system clock, rising edge
//   rstn          : async active-low reset, core state only (memories persist)
//   jtag_pin_TCK/TMS/TDI : JTAG inputs (TMS always ignored)
//   jtag_pin_TDO  : JTAG output
// Build option JTAG_BYPASS_EN: adds a 1-bit bypass register between TDI and
// TDO; without it TDO is tied low and the JTAG inputs are not used.
// Addresses above 8 KiB alias onto the same memories (upper bits dropped).
module riscv_soc_top
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic jtag_pin_TCK,
  input  logic jtag_pin_TMS,
  input  logic jtag_pin_TDI,
  output logic jtag_pin_TDO
);

  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic        mem_re;
  logic [3:0]  mem_wmask;
  logic        addr_unused;

  riscv riscv_inst (
    .clk       (clk),
    .rstn      (rstn),
    .inst_addr (inst_addr),
    .inst      (inst),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_wmask (mem_wmask),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  rom rom_inst (
    .clk       (clk),
    .addr      (inst_addr[ADDR_W-1:2]),
    .data      (inst),
    .load_en   (1'b0),
    .load_idx  ({IDX_W{1'b0}}),
    .load_data (32'h0)
  );

  ram ram_inst (
    .clk   (clk),
    .we    (mem_we),
    .wmask (mem_wmask),
    .addr  (mem_addr[ADDR_W-1:2]),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Byte offset is handled inside the core; RAM reads are unconditional.
  assign addr_unused = ^{inst_addr[31:ADDR_W], inst_addr[1:0],
                         mem_addr[31:ADDR_W], mem_addr[1:0], mem_re};

`ifdef JTAG_BYPASS_EN
  logic bypass_r;
  logic tdo_r;
  logic jtag_unused;

  assign jtag_unused = jtag_pin_TMS;

  // Bypass capture on rising TCK.
  always_ff @(posedge jtag_pin_TCK or negedge rstn) begin
    if (!rstn) begin
      bypass_r <= 1'b0;
    end else begin
      bypass_r <= jtag_pin_TDI;
    end
  end

  // TDO launch on falling TCK.
  always_ff @(negedge jtag_pin_TCK or negedge rstn) begin
    if (!rstn) begin
      tdo_r <= 1'b0;
    end else begin
      tdo_r <= bypass_r;
    end
  end

  assign jtag_pin_TDO = tdo_r;
`else
  logic jtag_unused;

  assign jtag_unused  = ^{jtag_pin_TCK, jtag_pin_TMS, jtag_pin_TDI};
  assign jtag_pin_TDO = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_soc_top.sv
// Bench for riscv_soc_top: preloads ROM/RAM hierarchically, runs directed and
// randomized load/store programs and compares registers and RAM against a
// byte-array model of the data memory.
module tb_riscv_soc_top;

  logic clk = 1'b0;
  logic rstn;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mm [0:8191];
  logic [31:0] exp_reg [0:31];
  logic [31:0] exp_known;
  logic [31:0] prog [$];

  always #5 clk = ~clk;

  riscv_soc_top dut (
    .clk          (clk),
    .rstn         (rstn),
    .jtag_pin_TCK (tck),
    .jtag_pin_TMS (tms),
    .jtag_pin_TDI (tdi),
    .jtag_pin_TDO (tdo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    checks++;
    assert (obs === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expected);
    end
  endtask

  function automatic logic [31:0] xreg(input int r);
    return dut.riscv_inst.register_inst.reg_mem[r];
  endfunction

  task automatic ram_poke(input logic [10:0] widx, input logic [31:0] w);
    int base;
    dut.ram_inst.ram_byte0.memory[widx] <= w[7:0];
    dut.ram_inst.ram_byte1.memory[widx] <= w[15:8];
    dut.ram_inst.ram_byte2.memory[widx] <= w[23:16];
    dut.ram_inst.ram_byte3.memory[widx] <= w[31:24];
    base = int'(widx) * 4;
    for (int b = 0; b < 4; b++) mm[base + b] = w[8*b +: 8];
  endtask

  function automatic logic [31:0] ram_peek(input logic [10:0] widx);
    return {dut.ram_inst.ram_byte3.memory[widx], dut.ram_inst.ram_byte2.memory[widx],
            dut.ram_inst.ram_byte1.memory[widx], dut.ram_inst.ram_byte0.memory[widx]};
  endfunction

  function automatic logic [31:0] model_word(input int a);
    return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
  endfunction

  // Little-endian load semantics straight from the ISA definition.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
    logic [7:0] b0, b1;
    b0 = mm[a];
    b1 = mm[a+1];
    case (f3)
      3'd0: return {{24{b0[7]}}, b0};
      3'd1: return {{16{b1[7]}}, b1, b0};
      3'd4: return {24'd0, b0};
      3'd5: return {16'd0, b1, b0};
      default: return model_word(a);
    endcase
  endfunction

  task automatic model_store(input int size, input int a, input logic [31:0] v);
    for (int i = 0; i < size; i++) mm[a+i] = v[8*i +: 8];
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  task automatic load_rom();
    for (int i = 0; i < prog.size(); i++) dut.rom_inst.memory[i] <= prog[i];
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int c = 0; c < budget && xreg(26) !== 32'd1; c++) @(negedge clk);
    check(tag, xreg(26), 32'd1);
  endtask

  initial begin
    logic [31:0] r300;
    logic [31:0] v;
    logic [3:0]  jbits;
    logic [2:0]  f3;
    logic [4:0]  rd;
    int          kind, size, a;
    logic [2:0]  load_f3 [0:4];

    load_f3[0] = 3'd0; load_f3[1] = 3'd1; load_f3[2] = 3'd2;
    load_f3[3] = 3'd4; load_f3[4] = 3'd5;
    rstn = 1'b0; tck = 1'b0; tms = 1'b0; tdi = 1'b0;
    exp_known = 32'h0;

    // Phase 1: reset, first fetch at 0, addi x26 retires quickly.
    prog.push_back(enc_i(12'd1, 5'd0, 3'd0, 5'd26, 7'h13));
    prog.push_back(32'h0000_006f);
    load_rom();
    @(negedge clk);
    check("reset_pc", dut.inst_addr, 32'h0);
    check("reset_x26", xreg(26), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("first_fetch", dut.inst_addr, 32'h0);
    wait_done(6, "x26_after_reset");

    // Phase 2: directed + randomized load/store program.
    @(negedge clk);
    rstn = 1'b0;
    prog.delete();
    r300 = $urandom;
    ram_poke(11'h040, 32'h00FF_00FF);
    ram_poke(11'h080, 32'h1122_3344);
    ram_poke(11'h0C0, r300);
    ram_poke(11'h1FF, 32'hDEAD_BEEF);
    for (int w = 11'h100; w < 11'h140; w++) ram_poke(11'(w), $urandom);

    prog.push_back(enc_s(12'h7FC, 5'd0, 5'd0, 3'd2));              // sw x0,0x7FC
    model_store(4, 32'h7FC, 32'h0);
    prog.push_back(enc_i(12'h100, 5'd0, 3'd2, 5'd5, 7'h03));       // lw x5,0x100
    prog.push_back(enc_i(12'h101, 5'd0, 3'd0, 5'd6, 7'h03));       // lb x6,0x101
    prog.push_back(enc_i(12'h100, 5'd0, 3'd0, 5'd7, 7'h03));       // lb x7,0x100
    prog.push_back(enc_i(12'hFAA, 5'd0, 3'd0, 5'd8, 7'h13));       // addi x8,x0,-86
    prog.push_back(enc_s(12'h203, 5'd8, 5'd0, 3'd0));              // sb x8,0x203
    model_store(1, 32'h203, 32'hAA);
    prog.push_back(enc_i(12'h200, 5'd0, 3'd2, 5'd9, 7'h03));       // lw x9,0x200
    prog.push_back(enc_lui(5'd10, 20'h0000C));                     // lui x10,0xC
    prog.push_back(enc_i(12'hEEF, 5'd10, 3'd0, 5'd10, 7'h13));     // addi x10,x10,-273
    prog.push_back(enc_s(12'h302, 5'd10, 5'd0, 3'd1));             // sh x10,0x302
    model_store(2, 32'h302, 32'hBEEF);
    prog.push_back(enc_i(12'h300, 5'd0, 3'd2, 5'd11, 7'h03));      // lw x11,0x300
    prog.push_back(enc_lui(5'd13, 20'h00002));                     // lui x13,0x2
    prog.push_back(enc_i(12'h100, 5'd13, 3'd2, 5'd12, 7'h03));     // lw x12,0x100(x13)

    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 7);
      if (kind < 3) begin
        size = 1 << kind;
        v = $urandom;
        a = 32'h400 + ($urandom_range(0, 255) & ~(size - 1));
        prog.push_back(enc_lui(5'd28, 20'((v + 32'h800) >> 12)));
        prog.push_back(enc_i(v[11:0], 5'd28, 3'd0, 5'd28, 7'h13));
        prog.push_back(enc_s(12'(a), 5'd28, 5'd0, 3'(kind)));
        exp_reg[28] = v;
        exp_known[28] = 1'b1;
        model_store(size, a, v);
      end else begin
        f3 = load_f3[kind - 3];
        size = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        a = 32'h400 + ($urandom_range(0, 255) & ~(size - 1));
        rd = 5'(14 + $urandom_range(0, 11));
        prog.push_back(enc_i(12'(a), 5'd0, f3, rd, 7'h03));
        exp_reg[rd] = model_load(f3, a);
        exp_known[rd] = 1'b1;
      end
    end
    prog.push_back(enc_i(12'd1, 5'd0, 3'd0, 5'd27, 7'h13));
    prog.push_back(enc_i(12'd1, 5'd0, 3'd0, 5'd26, 7'h13));
    prog.push_back(32'h0000_006f);
    load_rom();

    // Word 0 is a store: reset must keep it away from the RAM.
    repeat (3) @(negedge clk);
    check("we_in_reset", {31'd0, dut.riscv_inst.mem_we}, 32'h0);
    check("store_suppressed", ram_peek(11'h1FF), 32'hDEAD_BEEF);
    rstn = 1'b1;
    wait_done(3000, "prog_done");
    check("x27_pass", xreg(27), 32'd1);
    check("lw_x5", xreg(5), 32'h00FF_00FF);
    check("lb_x6", xreg(6), 32'h0000_0000);
    check("lb_x7", xreg(7), 32'hFFFF_FFFF);
    check("addi_x8", xreg(8), 32'hFFFF_FFAA);
    check("sb_then_lw", xreg(9), 32'hAA22_3344);
    check("lane3", {24'd0, dut.ram_inst.ram_byte3.memory[11'h080]}, 32'hAA);
    check("lane2", {24'd0, dut.ram_inst.ram_byte2.memory[11'h080]}, 32'h22);
    check("lane0", {24'd0, dut.ram_inst.ram_byte0.memory[11'h080]}, 32'h44);
    check("bEEf_x10", xreg(10), 32'h0000_BEEF);
    check("sh_then_lw", xreg(11), {16'hBEEF, r300[15:0]});
    check("wrap_x12", xreg(12), 32'h00FF_00FF);
    check("lui_x13", xreg(13), 32'h0000_2000);
    check("sw_word0", ram_peek(11'h1FF), 32'h0);
    for (int r = 14; r < 29; r++) begin
      if (exp_known[r]) check($sformatf("rnd_x%0d", r), xreg(r), exp_reg[r]);
    end
    for (int w = 32'h400; w < 32'h500; w += 4) begin
      check($sformatf("ram_%0h", w), ram_peek(11'(w >> 2)), model_word(w));
    end

    // Phase 3: reset mid-loop; core state clears, RAM persists, program reruns.
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_x5_clear", xreg(5), 32'h0);
    check("rst_pc", dut.inst_addr, 32'h0);
    check("ram_persist", ram_peek(11'h080), 32'hAA22_3344);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_done(3000, "rerun_done");
    check("rerun_x5", xreg(5), 32'h00FF_00FF);
    check("rerun_x9", xreg(9), 32'hAA22_3344);

    // Phase 4: JTAG.
    jbits = 4'b1101;
    check("tdo_idle", {31'd0, tdo}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tdi = jbits[k];
      #3 tck = 1'b1;
      #3 tck = 1'b0;
      #1;
`ifdef JTAG_BYPASS_EN
      check($sformatf("tdo_bit%0d", k), {31'd0, tdo}, {31'd0, jbits[k]});
`else
      check($sformatf("tdo_zero%0d", k), {31'd0, tdo}, 32'h0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
